// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control unit.
// Holds the opcode and ALU-select constants, the FSM state encoding, the
// opcode class enum, and the packed strobe bundle that the sequencer registers.
package cpu_pkg;

  localparam int OPW = 5;  // opcode / ALU-select width, IR[31:27]
  localparam int STW = 5;  // state register width

  localparam logic [OPW-1:0] OPC_LD   = 5'b00000;
  localparam logic [OPW-1:0] OPC_ST   = 5'b00010;
  localparam logic [OPW-1:0] OPC_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OPC_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OPC_AND  = 5'b00101;
  localparam logic [OPW-1:0] OPC_OR   = 5'b00110;
  localparam logic [OPW-1:0] OPC_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OPC_ANDI = 5'b01101;
  localparam logic [OPW-1:0] OPC_ORI  = 5'b01110;
  localparam logic [OPW-1:0] OPC_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OPC_HALT = 5'b11011;

  localparam logic [OPW-1:0] ALU_NONE = 5'b00000;
  localparam logic [OPW-1:0] ALU_ADD  = 5'b00011;
  localparam logic [OPW-1:0] ALU_SUB  = 5'b00100;
  localparam logic [OPW-1:0] ALU_AND  = 5'b00101;
  localparam logic [OPW-1:0] ALU_OR   = 5'b00110;

  typedef enum logic [STW-1:0] {
    ST_RST, ST_F0, ST_F1, ST_F2, ST_D,
    ST_E3, ST_E4, ST_E5, ST_E6, ST_E7, ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_ALU_R, CLS_ALU_I, CLS_LD, CLS_ST, CLS_HALT
  } opclass_e;

  // Strobes the sequencer actually drives; reserved outputs are tied off in the top.
  typedef struct packed {
    logic           ir_in;
    logic           zhigh_in;
    logic           zlow_in;
    logic           mar_in;
    logic           mdr_in;
    logic           y_in;
    logic           pc_out;
    logic           zlow_out;
    logic           mdr_out;
    logic           c_out;
    logic           gra;
    logic           grb;
    logic           grc;
    logic           r_in;
    logic           r_out;
    logic           ba_out;
    logic           read;
    logic           write;
    logic           inc_pc;
    logic           run;
    logic [OPW-1:0] op;
  } ctrl_t;

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational opcode classifier.
// opcode  : IR[31:27]
// cls     : instruction class; undefined opcodes classify as CLS_NOP
// alu_sel : ALU select used in E4 (ld/st use add for address generation)
module opcode_class_decode
  import cpu_pkg::*;
(
  input  logic [OPW-1:0] opcode,
  output opclass_e       cls,
  output logic [OPW-1:0] alu_sel
);

  always_comb begin
    cls     = CLS_NOP;
    alu_sel = ALU_NONE;
    case (opcode)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: begin
        cls     = CLS_ALU_R;
        alu_sel = opcode;  // register ops share their opcode with the ALU select
      end
      OPC_ADDI: begin cls = CLS_ALU_I; alu_sel = ALU_ADD; end
      OPC_ANDI: begin cls = CLS_ALU_I; alu_sel = ALU_AND; end
      OPC_ORI:  begin cls = CLS_ALU_I; alu_sel = ALU_OR;  end
      OPC_LD:   begin cls = CLS_LD;    alu_sel = ALU_ADD; end
      OPC_ST:   begin cls = CLS_ST;    alu_sel = ALU_ADD; end
      OPC_HALT: cls = CLS_HALT;
      default:  cls = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit sitting directly upstream of the datapath.
// Sequences fetch (F0..F2), one decode cycle (D) and the execute states
// (E3..E7) for ALU reg/imm, ld, st, nop and halt.
// Inputs : Clock, Clear (sync active-high), IR, CON_FF (reserved), Stop
// Outputs: register load enables, bus drive enables, register select and
//          memory control strobes, OP (ALU select), Run.
// Strobes are computed from the next state and registered, so every output
// is a pure function of the current state (OP additionally carries the
// decoded ALU select, which is stable while the instruction executes).
module control_sequencer
  import cpu_pkg::*;
(
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  output logic        PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, OutPort, Yin,
  output logic        PCout, HIout, LOout, ZHighout, ZLowout, InPort, MDRout, Cout,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, IncPC, CON_In, GLR,
  output logic [4:0]  OP,
  output logic        Run
);

  state_e         state_q, state_d;
  ctrl_t          ctrl_q, ctrl_d;
  opclass_e       cls;
  logic [OPW-1:0] alu_sel;
  logic           is_mem;

  // CON_FF and the operand fields are consumed by the datapath / later revisions.
  logic unused_inputs;
  assign unused_inputs = ^{CON_FF, IR[26:0]};

  opcode_class_decode u_dec (
    .opcode  (IR[31:27]),
    .cls     (cls),
    .alu_sel (alu_sel)
  );

  assign is_mem = (cls == CLS_LD) || (cls == CLS_ST);

  // Next state. Stop only matters on the edge leaving an instruction's last state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST: state_d = ST_F0;
      ST_F0:  state_d = ST_F1;
      ST_F1:  state_d = ST_F2;
      ST_F2:  state_d = ST_D;
      ST_D: begin
        case (cls)
          CLS_ALU_R, CLS_ALU_I, CLS_LD, CLS_ST: state_d = ST_E3;
          CLS_HALT: state_d = ST_HALT;
          default:  state_d = Stop ? ST_HALT : ST_F0;
        endcase
      end
      ST_E3:   state_d = ST_E4;
      ST_E4:   state_d = ST_E5;
      ST_E5:   state_d = is_mem ? ST_E6 : (Stop ? ST_HALT : ST_F0);
      ST_E6:   state_d = ST_E7;
      ST_E7:   state_d = Stop ? ST_HALT : ST_F0;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST;
    endcase
  end

  // Strobes for the state being entered.
  always_comb begin
    ctrl_d     = '0;
    ctrl_d.run = (state_d != ST_HALT);
    case (state_d)
      ST_F0: begin ctrl_d.pc_out = 1'b1; ctrl_d.mar_in = 1'b1; ctrl_d.inc_pc = 1'b1; end
      ST_F1: begin ctrl_d.read = 1'b1; ctrl_d.mdr_in = 1'b1; end
      ST_F2: begin ctrl_d.mdr_out = 1'b1; ctrl_d.ir_in = 1'b1; end
      ST_E3: begin
        ctrl_d.grb    = 1'b1;
        ctrl_d.y_in   = 1'b1;
        ctrl_d.ba_out = is_mem;
        ctrl_d.r_out  = !is_mem;
      end
      ST_E4: begin
        ctrl_d.op       = alu_sel;
        ctrl_d.zlow_in  = 1'b1;
        ctrl_d.zhigh_in = !is_mem;  // address generation only needs the low half
        ctrl_d.c_out    = (cls != CLS_ALU_R);
        ctrl_d.grc      = (cls == CLS_ALU_R);
        ctrl_d.r_out    = (cls == CLS_ALU_R);
      end
      ST_E5: begin
        ctrl_d.zlow_out = 1'b1;
        ctrl_d.mar_in   = is_mem;
        ctrl_d.gra      = !is_mem;
        ctrl_d.r_in     = !is_mem;
      end
      ST_E6: begin
        ctrl_d.mdr_in = 1'b1;
        // st loads MDR from the bus (Read low); ld loads it from memory
        ctrl_d.read   = (cls == CLS_LD);
        ctrl_d.gra    = (cls == CLS_ST);
        ctrl_d.r_out  = (cls == CLS_ST);
      end
      ST_E7: begin
        ctrl_d.write   = (cls == CLS_ST);
        ctrl_d.mdr_out = (cls == CLS_LD);
        ctrl_d.gra     = (cls == CLS_LD);
        ctrl_d.r_in    = (cls == CLS_LD);
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q    <= ST_RST;
      ctrl_q     <= '0;
      ctrl_q.run <= 1'b1;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign IRin     = ctrl_q.ir_in;
  assign ZHighin  = ctrl_q.zhigh_in;
  assign ZLowin   = ctrl_q.zlow_in;
  assign MARin    = ctrl_q.mar_in;
  assign MDRin    = ctrl_q.mdr_in;
  assign Yin      = ctrl_q.y_in;
  assign PCout    = ctrl_q.pc_out;
  assign ZLowout  = ctrl_q.zlow_out;
  assign MDRout   = ctrl_q.mdr_out;
  assign Cout     = ctrl_q.c_out;
  assign Gra      = ctrl_q.gra;
  assign Grb      = ctrl_q.grb;
  assign Grc      = ctrl_q.grc;
  assign Rin      = ctrl_q.r_in;
  assign Rout     = ctrl_q.r_out;
  assign BAout    = ctrl_q.ba_out;
  assign Read     = ctrl_q.read;
  assign Write    = ctrl_q.write;
  assign IncPC    = ctrl_q.inc_pc;
  assign Run      = ctrl_q.run;
  assign OP       = ctrl_q.op;

  // Reserved for later revisions
  assign PCin     = 1'b0;
  assign HIin     = 1'b0;
  assign LOin     = 1'b0;
  assign OutPort  = 1'b0;
  assign HIout    = 1'b0;
  assign LOout    = 1'b0;
  assign ZHighout = 1'b0;
  assign InPort   = 1'b0;
  assign CON_In   = 1'b0;
  assign GLR      = 1'b0;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic        Clock, Clear, CON_FF, Stop;
  logic [31:0] IR;
  logic PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, OutPort, Yin;
  logic PCout, HIout, LOout, ZHighout, ZLowout, InPort, MDRout, Cout;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, IncPC, CON_In, GLR;
  logic [4:0] OP;
  logic Run;

  control_sequencer dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
    .PCin(PCin), .IRin(IRin), .HIin(HIin), .LOin(LOin), .ZHighin(ZHighin),
    .ZLowin(ZLowin), .MARin(MARin), .MDRin(MDRin), .OutPort(OutPort), .Yin(Yin),
    .PCout(PCout), .HIout(HIout), .LOout(LOout), .ZHighout(ZHighout),
    .ZLowout(ZLowout), .InPort(InPort), .MDRout(MDRout), .Cout(Cout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Read(Read), .Write(Write), .IncPC(IncPC), .CON_In(CON_In), .GLR(GLR),
    .OP(OP), .Run(Run)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic [34:0] act;
  assign act = {OP, Run, GLR, CON_In, IncPC, Write, Read, BAout, Rout, Rin, Grc, Grb, Gra,
                Cout, MDRout, InPort, ZLowout, ZHighout, LOout, HIout, PCout, Yin, OutPort,
                MDRin, MARin, ZLowin, ZHighin, LOin, HIin, IRin, PCin};

  localparam logic [34:0] M_IRIN  = 35'd1 << 1;
  localparam logic [34:0] M_ZHI   = 35'd1 << 4;
  localparam logic [34:0] M_ZLI   = 35'd1 << 5;
  localparam logic [34:0] M_MARIN = 35'd1 << 6;
  localparam logic [34:0] M_MDRIN = 35'd1 << 7;
  localparam logic [34:0] M_YIN   = 35'd1 << 9;
  localparam logic [34:0] M_PCOUT = 35'd1 << 10;
  localparam logic [34:0] M_ZLO   = 35'd1 << 14;
  localparam logic [34:0] M_MDROUT= 35'd1 << 16;
  localparam logic [34:0] M_COUT  = 35'd1 << 17;
  localparam logic [34:0] M_GRA   = 35'd1 << 18;
  localparam logic [34:0] M_GRB   = 35'd1 << 19;
  localparam logic [34:0] M_GRC   = 35'd1 << 20;
  localparam logic [34:0] M_RIN   = 35'd1 << 21;
  localparam logic [34:0] M_ROUT  = 35'd1 << 22;
  localparam logic [34:0] M_BAOUT = 35'd1 << 23;
  localparam logic [34:0] M_READ  = 35'd1 << 24;
  localparam logic [34:0] M_WRITE = 35'd1 << 25;
  localparam logic [34:0] M_INCPC = 35'd1 << 26;
  localparam logic [34:0] M_RUN   = 35'd1 << 29;

  localparam logic [34:0] X_RST  = M_RUN;
  localparam logic [34:0] X_F0   = M_RUN | M_PCOUT | M_MARIN | M_INCPC;
  localparam logic [34:0] X_F1   = M_RUN | M_READ | M_MDRIN;
  localparam logic [34:0] X_F2   = M_RUN | M_MDROUT | M_IRIN;
  localparam logic [34:0] X_D    = M_RUN;
  localparam logic [34:0] X_E3A  = M_RUN | M_GRB | M_ROUT | M_YIN;
  localparam logic [34:0] X_E5A  = M_RUN | M_ZLO | M_GRA | M_RIN;
  localparam logic [34:0] X_E3M  = M_RUN | M_GRB | M_BAOUT | M_YIN;
  localparam logic [34:0] X_E4M  = M_RUN | M_COUT | M_ZLI | (35'd3 << 30);
  localparam logic [34:0] X_E5M  = M_RUN | M_ZLO | M_MARIN;
  localparam logic [34:0] X_E6L  = M_RUN | M_READ | M_MDRIN;
  localparam logic [34:0] X_E7L  = M_RUN | M_MDROUT | M_GRA | M_RIN;
  localparam logic [34:0] X_E6S  = M_RUN | M_GRA | M_ROUT | M_MDRIN;
  localparam logic [34:0] X_E7S  = M_RUN | M_WRITE;
  localparam logic [34:0] X_HALT = 35'd0;

  function automatic logic [34:0] x_e4r(input logic [4:0] op);
    logic [34:0] v;
    v = M_RUN | M_GRC | M_ROUT | M_ZHI | M_ZLI;
    v[34:30] = op;
    return v;
  endfunction

  function automatic logic [34:0] x_e4i(input logic [4:0] op);
    logic [34:0] v;
    v = M_RUN | M_COUT | M_ZHI | M_ZLI;
    v[34:30] = op;
    return v;
  endfunction

  logic [34:0] q_v[$];
  string       q_n[$];
  int checks = 0;
  int errors = 0;

  task automatic cyc(input logic [34:0] e, input string n);
    @(posedge Clock);
    q_v.push_back(e);
    q_n.push_back(n);
    #1;
  endtask

  task automatic fetch(input logic [31:0] ir);
    cyc(X_F0, "f0");
    cyc(X_F1, "f1");
    cyc(X_F2, "f2");
    IR = ir;
    cyc(X_D, "d");
  endtask

  always @(negedge Clock) begin
    if (q_v.size() > 0) begin
      logic [34:0] e;
      string n;
      e = q_v.pop_front();
      n = q_n.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s act=%h exp=%h", n, act, e);
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    Clear = 1'b1; Stop = 1'b0; CON_FF = 1'b0; IR = 32'h0;
    cyc(X_RST, "reset");
    Clear = 1'b0;

    fetch(32'h71180025);
    cyc(X_E3A, "ori_e3"); cyc(x_e4i(5'b00110), "ori_e4"); cyc(X_E5A, "ori_e5");
    fetch(32'h611FFFFD);
    cyc(X_E3A, "addi_e3"); cyc(x_e4i(5'b00011), "addi_e4"); cyc(X_E5A, "addi_e5");
    fetch(32'h69180025);
    cyc(X_E3A, "andi_e3"); cyc(x_e4i(5'b00101), "andi_e4"); cyc(X_E5A, "andi_e5");
    fetch(32'h18A20000);
    cyc(X_E3A, "add_e3"); cyc(x_e4r(5'b00011), "add_e4"); cyc(X_E5A, "add_e5");
    fetch(32'h20A20000);
    cyc(X_E3A, "sub_e3"); cyc(x_e4r(5'b00100), "sub_e4"); cyc(X_E5A, "sub_e5");
    fetch(32'h00800010);
    cyc(X_E3M, "ld_e3"); cyc(X_E4M, "ld_e4"); cyc(X_E5M, "ld_e5");
    cyc(X_E6L, "ld_e6"); cyc(X_E7L, "ld_e7");
    fetch(32'h10800010);
    cyc(X_E3M, "st_e3"); cyc(X_E4M, "st_e4"); cyc(X_E5M, "st_e5");
    cyc(X_E6S, "st_e6"); cyc(X_E7S, "st_e7");
    fetch(32'hD0000000);
    fetch(32'hF8000000);
    fetch(32'h30A20000);
    cyc(X_E3A, "or_e3");
    Stop = 1'b1;
    cyc(x_e4r(5'b00110), "or_e4_stop_ignored");
    Stop = 1'b0;
    cyc(X_E5A, "or_e5");
    Stop = 1'b1;
    cyc(X_HALT, "stop_halt");
    Stop = 1'b0;
    for (int i = 0; i < 3; i++) cyc(X_HALT, "stop_halt_hold");
    Clear = 1'b1;
    cyc(X_RST, "clear_from_halt");
    Clear = 1'b0;
    fetch(32'hD8000000);
    for (int i = 0; i < 20; i++) cyc(X_HALT, "halt_hold");
    checks++;
    if (Run !== 1'b0 || IncPC !== 1'b0 || PCout !== 1'b0) begin
      errors++;
      $display("FAIL halt_direct Run=%b IncPC=%b PCout=%b", Run, IncPC, PCout);
    end
    Clear = 1'b1;
    cyc(X_RST, "halt_clear_rst");
    Clear = 1'b0;
    fetch(32'h18A20000);
    cyc(X_E3A, "abort_e3"); cyc(x_e4r(5'b00011), "abort_e4");
    Clear = 1'b1;
    cyc(X_RST, "abort_rst");
    Clear = 1'b0;
    fetch(32'hD0000000);
    Stop = 1'b1;
    cyc(X_HALT, "nop_stop_halt");
    Stop = 1'b0;
    cyc(X_HALT, "nop_stop_hold");
    Clear = 1'b1;
    cyc(X_RST, "final_rst");
    Clear = 1'b0;
    cyc(X_F0, "final_f0");
    checks++;
    if (Run !== 1'b1 || PCout !== 1'b1 || MARin !== 1'b1 || IncPC !== 1'b1 || OP !== 5'b00000) begin
      errors++;
      $display("FAIL f0_direct Run=%b PCout=%b MARin=%b IncPC=%b OP=%b", Run, PCout, MARin, IncPC, OP);
    end

    repeat (2) @(negedge Clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
